// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and helpers for the display path.
package seg7_pkg;

    localparam int         SEG_W          = 7;
    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam int         DEF_NUM_DIGITS = 6;

    localparam logic [6:0] SEG_D0 = 7'b0000001;
    localparam logic [6:0] SEG_D1 = 7'b1001111;
    localparam logic [6:0] SEG_D2 = 7'b0010010;
    localparam logic [6:0] SEG_D3 = 7'b0000110;
    localparam logic [6:0] SEG_D4 = 7'b1001100;
    localparam logic [6:0] SEG_D5 = 7'b0100100;
    localparam logic [6:0] SEG_D6 = 7'b0100000;
    localparam logic [6:0] SEG_D7 = 7'b0001111;
    localparam logic [6:0] SEG_D8 = 7'b0000000;
    localparam logic [6:0] SEG_D9 = 7'b0000100;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    function automatic logic [7:0] onehot_n(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

endpackage

// File: rtl/seg7_refresh_div.sv
// Slot timer: divides clk into digit slots, tracks the scanned digit
// and flags slot starts, blank/drive phase and frame wrap.
module seg7_refresh_div
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [2:0] idx_q_o,
    output logic [2:0] idx_d_o,
    output phase_e     phase_o,
    output logic       slot_start_o,
    output logic       frame_tick_o
);

    localparam int               DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             slot_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            idx_q  <= '0;
            run_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            run_q  <= run_d;
            tick_q <= tick_d;
        end
    end

    // run_q low means the next enabled edge opens a fresh slot at idx_q
    always_comb begin
        div_d      = div_q;
        idx_d      = idx_q;
        run_d      = run_q;
        tick_d     = 1'b0;
        slot_start = 1'b0;
        unique case (1'b1)
            !en_i: begin
                div_d = '0;
                run_d = 1'b0;
            end
            en_i && !run_q: begin
                div_d      = '0;
                run_d      = 1'b1;
                slot_start = 1'b1;
            end
            en_i && run_q && (div_q == DIV_LAST): begin
                div_d      = '0;
                slot_start = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            en_i && run_q && (div_q != DIV_LAST): begin
                div_d = div_q + 1'b1;
            end
            default: begin
                div_d = '0;
            end
        endcase
    end

    always_comb begin
        phase_o      = PH_BLANK;
        if (en_i && (int'(div_d) >= BLANK_CYC)) begin
            phase_o = PH_DRIVE;
        end
        idx_q_o      = idx_q;
        idx_d_o      = idx_d;
        slot_start_o = slot_start;
        frame_tick_o = tick_q;
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment driver with per-slot blanking.
// Optional colon blink: define SEG7_SCAN_COLON_BLINK_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
`ifdef SEG7_SCAN_COLON_BLINK_EN
    input  logic                        blink_tick,
`endif
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
    output logic [SEG_W-1:0]            seg_n,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        dp_n,
    output logic [2:0]                  scan_idx,
    output logic                        frame_tick
);

    logic [2:0] idx_q, idx_d;
    phase_e     phase;
    logic       slot_start;
    logic       tick;

    seg7_refresh_div #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .idx_q_o      (idx_q),
        .idx_d_o      (idx_d),
        .phase_o      (phase),
        .slot_start_o (slot_start),
        .frame_tick_o (tick)
    );

    logic [SEG_W-1:0]      pat_q, pat_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_q, dp_d;
    logic [7:0]            an_full;
    logic                  drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= SEG_BLANK;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            pat_q <= pat_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

`ifdef SEG7_SCAN_COLON_BLINK_EN
    logic colon_q, colon_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colon_q <= 1'b0;
        end else begin
            colon_q <= colon_d;
        end
    end

    always_comb begin
        colon_d = colon_q ^ blink_tick;
    end
`endif

    // Capture on the slot-opening edge so mid-slot seg_in edits cannot tear
    always_comb begin
        pat_d   = pat_q;
        if (slot_start) begin
            pat_d = seg_in[int'(idx_d)*SEG_W +: SEG_W];
        end
        drive   = (phase == PH_DRIVE);
        an_full = onehot_n(idx_d);
        an_d    = drive ? an_full[NUM_DIGITS-1:0] : '1;
        seg_d   = drive ? pat_d : SEG_BLANK;
`ifdef SEG7_SCAN_COLON_BLINK_EN
        dp_d    = ~(drive && colon_d &&
                    ((idx_d == 3'd2) || (idx_d == 3'd4)));
`else
        dp_d    = 1'b1;
`endif
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign dp_n       = dp_q;
    assign scan_idx   = idx_q;
    assign frame_tick = tick;

endmodule
